// File: rtl/pixel_filter_pkg.sv
// Shared definitions for the 3x3 streaming pixel filter: mode codes, FSM states,
// and the width helper for per-frame pixel counters.
package pixel_filter_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_THR    = 2'd1;
  localparam logic [1:0] MODE_MED    = 2'd2;
  localparam logic [1:0] MODE_MEDTHR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  function automatic int pix_cnt_w(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/pixel_filter_3x3_median9.sv
// Combinational 9-input median: 19 compare-exchange stages, smallest known
// network for the median of nine.
module median9
  import pixel_filter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [9*DATA_W-1:0] i_pix,
  output logic [DATA_W-1:0]   o_med
);

  // returns {low, high}
  function automatic logic [2*DATA_W-1:0] cas(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a > b) ? {b, a} : {a, b};
  endfunction

  always_comb begin
    logic [DATA_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    p0 = i_pix[0*DATA_W +: DATA_W];
    p1 = i_pix[1*DATA_W +: DATA_W];
    p2 = i_pix[2*DATA_W +: DATA_W];
    p3 = i_pix[3*DATA_W +: DATA_W];
    p4 = i_pix[4*DATA_W +: DATA_W];
    p5 = i_pix[5*DATA_W +: DATA_W];
    p6 = i_pix[6*DATA_W +: DATA_W];
    p7 = i_pix[7*DATA_W +: DATA_W];
    p8 = i_pix[8*DATA_W +: DATA_W];
    {p1, p2} = cas(p1, p2);
    {p4, p5} = cas(p4, p5);
    {p7, p8} = cas(p7, p8);
    {p0, p1} = cas(p0, p1);
    {p3, p4} = cas(p3, p4);
    {p6, p7} = cas(p6, p7);
    {p1, p2} = cas(p1, p2);
    {p4, p5} = cas(p4, p5);
    {p7, p8} = cas(p7, p8);
    {p0, p3} = cas(p0, p3);
    {p5, p8} = cas(p5, p8);
    {p4, p7} = cas(p4, p7);
    {p3, p6} = cas(p3, p6);
    {p1, p4} = cas(p1, p4);
    {p2, p5} = cas(p2, p5);
    {p4, p7} = cas(p4, p7);
    {p4, p2} = cas(p4, p2);
    {p6, p4} = cas(p6, p4);
    {p4, p2} = cas(p4, p2);
    o_med = p4;
  end

endmodule

// File: rtl/pixel_filter_3x3.sv
// Streaming 3x3 pixel filter (passthrough / threshold / median / median+threshold).
// Optional FILTER_STATS_EN adds frame_hi_count, the per-frame count of outputs above THRESH.
//
// state | meaning
// IDLE  | drop pixels until one carries in_sof
// FILL  | priming line buffers, first IMG_W+1 pixels, no output
// RUN   | one output per accepted input
// FLUSH | input blocked, IMG_W+1 self-timed steps drain the window
module pixel_filter_3x3
  import pixel_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int THRESH = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof
`ifdef FILTER_STATS_EN
  ,
  output logic [pix_cnt_w(IMG_W, IMG_H)-1:0] frame_hi_count
`endif
);

  localparam int KW = pix_cnt_w(IMG_W, IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);

  localparam logic [KW-1:0]     K_FILL_END = KW'(IMG_W);
  localparam logic [KW-1:0]     K_LAST     = KW'(IMG_W * IMG_H - 1);
  localparam logic [KW-1:0]     K_ONE      = KW'(1);
  localparam logic [FW-1:0]     FLUSH_LEN  = FW'(IMG_W + 1);
  localparam logic [FW-1:0]     FLUSH_ONE  = FW'(1);
  localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [DATA_W-1:0] THR_LVL    = DATA_W'(THRESH);

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [KW-1:0]       r_k;
  logic [FW-1:0]       r_flush_left;
  logic [CW-1:0]       r_ocol;
  logic [RW-1:0]       r_orow;
  logic                r_out_valid;
  logic                r_out_sof;
  logic                r_out_eof;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   r_lb0 [IMG_W];
  logic [DATA_W-1:0]   r_lb1 [IMG_W];
  logic [DATA_W-1:0]   r_col0 [3];
  logic [DATA_W-1:0]   r_col1 [3];

  logic                w_out_free;
  logic                w_in_acc;
  logic                w_restart;
  logic                w_flush_step;
  logic                w_shift;
  logic                w_emit;
  logic                w_emit_sof;
  logic                w_emit_eof;
  logic                w_interior;
  logic                w_use_med;
  logic                w_use_thr;
  logic [DATA_W-1:0]   w_pix;
  logic [DATA_W-1:0]   w_new_top;
  logic [DATA_W-1:0]   w_new_mid;
  logic [DATA_W-1:0]   w_med;
  logic [DATA_W-1:0]   w_pre;
  logic [DATA_W-1:0]   w_val;

  assign w_out_free   = !r_out_valid || out_ready;
  assign in_ready     = (r_state != ST_FLUSH) && w_out_free;
  assign w_in_acc     = in_valid && in_ready;
  assign w_restart    = w_in_acc && in_sof;
  assign w_flush_step = (r_state == ST_FLUSH) && w_out_free;
  assign w_shift      = (w_in_acc && ((r_state != ST_IDLE) || in_sof)) || w_flush_step;
  assign w_emit       = ((r_state == ST_RUN) && w_in_acc && !in_sof) || w_flush_step;
  assign w_emit_sof   = (r_orow == '0) && (r_ocol == '0);
  assign w_emit_eof   = (r_state == ST_FLUSH) && (r_flush_left == FLUSH_ONE);

  // Window is {r_col0, r_col1, incoming column}; the centre sits in r_col1.
  assign w_pix     = (r_state == ST_FLUSH) ? '0 : in_data;
  assign w_new_top = r_lb1[IMG_W-1];
  assign w_new_mid = r_lb0[IMG_W-1];

  median9 #(.DATA_W(DATA_W)) u_median9 (
    .i_pix ({w_pix, w_new_mid, w_new_top,
             r_col1[2], r_col1[1], r_col1[0],
             r_col0[2], r_col0[1], r_col0[0]}),
    .o_med (w_med)
  );

  assign w_interior = (r_orow != '0) && (r_orow != ROW_LAST) &&
                      (r_ocol != '0) && (r_ocol != COL_LAST);
  assign w_use_med  = (r_mode == MODE_MED) || (r_mode == MODE_MEDTHR);
  assign w_use_thr  = (r_mode == MODE_THR) || (r_mode == MODE_MEDTHR);
  assign w_pre      = (w_use_med && w_interior) ? w_med : r_col1[1];
  assign w_val      = !w_use_thr ? w_pre : ((w_pre > THR_LVL) ? '1 : '0);

  always_ff @(posedge clk) begin
    if (w_shift) begin
      r_lb0[0] <= w_pix;
      r_lb1[0] <= w_new_mid;
      for (int i = 1; i < IMG_W; i++) begin
        r_lb0[i] <= r_lb0[i-1];
        r_lb1[i] <= r_lb1[i-1];
      end
      r_col0    <= r_col1;
      r_col1[0] <= w_new_top;
      r_col1[1] <= w_new_mid;
      r_col1[2] <= w_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_PASS;
      r_k          <= '0;
      r_flush_left <= '0;
      r_ocol       <= '0;
      r_orow       <= '0;
      r_out_valid  <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_out_data   <= '0;
    end else if (w_restart) begin
      // in_sof always (re)starts a frame, whatever state we were in
      r_state      <= ST_FILL;
      r_mode       <= mode;
      r_k          <= K_ONE;
      r_flush_left <= '0;
      r_ocol       <= '0;
      r_orow       <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_val;
        r_out_sof   <= w_emit_sof;
        r_out_eof   <= w_emit_eof;
        if (r_ocol == COL_LAST) begin
          r_ocol <= '0;
          r_orow <= r_orow + 1'b1;
        end else begin
          r_ocol <= r_ocol + 1'b1;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_FILL: if (w_in_acc) begin
          r_k <= r_k + 1'b1;
          if (r_k == K_FILL_END) r_state <= ST_RUN;
        end
        ST_RUN: if (w_in_acc) begin
          r_k <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_state      <= ST_FLUSH;
            r_flush_left <= FLUSH_LEN;
          end
        end
        ST_FLUSH: if (w_flush_step) begin
          r_flush_left <= r_flush_left - 1'b1;
          if (r_flush_left == FLUSH_ONE) r_state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;

`ifdef FILTER_STATS_EN
  logic [KW-1:0] r_hi_cnt;
  logic [KW-1:0] w_hi_inc;

  assign w_hi_inc = {{(KW-1){1'b0}}, (w_val > THR_LVL)};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi_cnt <= '0;
    end else if (w_emit && !w_restart) begin
      r_hi_cnt <= w_emit_sof ? w_hi_inc : (r_hi_cnt + w_hi_inc);
    end
  end

  assign frame_hi_count = r_hi_cnt;
`endif

endmodule

// File: tb/tb_pixel_filter_3x3.sv
// Directed bench for pixel_filter_3x3 on a 4x4 frame: all modes, latency, flush,
// backpressure, mid-frame restart and mid-frame reset.
module tb_pixel_filter_3x3;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;
  logic       toggle_en = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
`ifdef FILTER_STATS_EN
  logic [4:0] frame_hi_count;
`endif

  pixel_filter_3x3 #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .THRESH(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof)
`ifdef FILTER_STATS_EN
    ,
    .frame_hi_count (frame_hi_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  logic [9:0] q_out[$];

  int pix_alt[16]  = '{128,129,128,129, 128,129,128,129, 128,129,128,129, 128,129,128,129};
  int exp_alt[16]  = '{0,255,0,255, 0,255,0,255, 0,255,0,255, 0,255,0,255};
  int pix_a[16]    = '{250,10,10,10, 10,200,10,10, 10,10,10,10, 10,10,10,5};
  int exp_a2[16]   = '{250,10,10,10, 10,10,10,10, 10,10,10,10, 10,10,10,5};
  int exp_a3[16]   = '{255,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
  int pix_f[16]    = '{9,1,7,3, 2,8,4,6, 5,0,9,2, 7,3,1,8};
  int exp_f2[16]   = '{9,1,7,3, 2,5,4,6, 5,4,4,2, 7,3,1,8};
  int pix_ramp[16] = '{0,16,32,48, 64,80,96,112, 128,144,160,176, 192,208,224,240};
  int exp_ramp3[16]= '{0,0,0,0, 0,0,0,0, 0,255,255,255, 255,255,255,255};
  int exp_pass[16] = '{0,1,2,3, 4,5,6,7, 8,9,10,11, 12,13,14,15};

  always @(negedge clk)
    if (!reset && out_valid && out_ready) q_out.push_back({out_sof, out_eof, out_data});

  always @(posedge clk) begin
    #1;
    out_ready = toggle_en ? ~out_ready : 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic push_px(input logic [7:0] d, input logic s);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_val("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int pix[16], input logic [1:0] md);
    q_out.delete();
    mode = md;
    for (int i = 0; i < N; i++) push_px(8'(pix[i]), i == 0);
  endtask

  task automatic check_frame(input string tag, input int want[16]);
    int guard = 0;
    while (q_out.size() < N && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_val($sformatf("%s_count", tag), q_out.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < q_out.size()) begin
        check_val($sformatf("%s_d%0d", tag, i), q_out[i][7:0], want[i]);
        check_val($sformatf("%s_flags%0d", tag, i), q_out[i][9:8],
                  ((i == 0) ? 2 : 0) | ((i == N-1) ? 1 : 0));
      end
    end
    q_out.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_sof", out_sof, 0);
    check_val("rst_out_eof", out_eof, 0);
    check_val("rst_in_ready", in_ready, 1);

    // passthrough with latency and flush timing
    q_out.delete();
    mode = 2'd0;
    for (int i = 0; i < N; i++) begin
      push_px(8'(i), i == 0);
      if (i == 4) check_val("lat_none_yet", out_valid, 0);
      if (i == 5) begin
        check_val("lat_valid", out_valid, 1);
        check_val("lat_data", out_data, 0);
        check_val("lat_sof", out_sof, 1);
      end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check_val($sformatf("flush_in_ready%0d", j), in_ready, 0);
    end
    @(negedge clk);
    check_val("flush_end_in_ready", in_ready, 1);
    check_val("flush_end_eof", out_eof, 1);
    check_val("flush_end_data", out_data, 15);
    check_frame("m0", exp_pass);

    send_frame(pix_alt, 2'd1);
    check_frame("m1", exp_alt);

    send_frame(pix_a, 2'd2);
    check_frame("m2a", exp_a2);

    send_frame(pix_f, 2'd2);
    check_frame("m2f", exp_f2);

    send_frame(pix_ramp, 2'd3);
    check_frame("m3ramp", exp_ramp3);
`ifdef FILTER_STATS_EN
    check_val("hi_count_ramp", frame_hi_count, 7);
`endif

    send_frame(pix_a, 2'd3);
    check_frame("m3a", exp_a3);
`ifdef FILTER_STATS_EN
    check_val("hi_count_a", frame_hi_count, 1);
`endif

    // backpressure: out_ready alternates every cycle
    toggle_en = 1'b1;
    send_frame(pix_f, 2'd2);
    check_frame("m2stall", exp_f2);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // in_sof at k=7 restarts in a new mode
    q_out.delete();
    mode = 2'd0;
    for (int i = 0; i < 7; i++) push_px(8'(i), i == 0);
    check_val("rs_pre_valid", out_valid, 1);
    check_val("rs_pre_data", out_data, 1);
    mode = 2'd1;
    push_px(8'd128, 1'b1);
    check_val("rs_drop_valid", out_valid, 0);
    q_out.delete();
    for (int i = 1; i < N; i++) push_px(8'(pix_alt[i]), 1'b0);
    check_frame("rs_new", exp_alt);

    // reset pulse mid-RUN, then a stray non-sof pixel, then a clean frame
    mode = 2'd0;
    for (int i = 0; i < 10; i++) push_px(8'(i), i == 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 1);
    push_px(8'd77, 1'b0);
    send_frame(pix_f, 2'd2);
    check_frame("midrst_new", exp_f2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
